// File: rtl/uart_pkg.sv
// Shared definitions for the MMIO UART transmitter: register map, field layout,
// transmit FSM states and the reset baud divisor.
package uart_pkg;

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 16;

  // 115200 baud from a 50 MHz clock (bit period is divisor + 1 cycles)
  localparam int unsigned UART_DEFAULT_DIV = 433;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_DIVISOR = 4'h8;
  localparam logic [3:0] OFF_CTRL    = 4'hC;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;
  localparam int unsigned ST_CNT_W   = 8;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_CLEAR  = 2;

  typedef struct packed {
    logic [19:0]         rsvd;
    logic [ST_CNT_W-1:0] count;
    logic                ovf;
    logic                busy;
    logic                empty;
    logic                full;
  } status_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO: power-of-two depth, wrapping pointers, occupancy count,
// single-cycle clear that also discards a simultaneous push.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO still fits when a pop frees a slot in the same cycle
  assign pop_ok  = pop && !empty;
  assign push_ok = push && !clear && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, baud divider, bit counter
// and transmit FSM around a byte FIFO.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bus_cs,
  input  logic             bus_wr,
  input  logic             bus_rd,
  input  logic [BUS_W-1:0] bus_addr,
  input  logic [BUS_W-1:0] bus_wr_data,
  output logic [BUS_W-1:0] bus_rd_data,
  output logic             tx,
  output logic             irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              wr_en, rd_en;
  logic [3:0]        reg_off;
  logic              push, pop, clear, ovf_set;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_rd_data;
  status_t           status;
  logic [BUS_W-1:0]  rd_mux;
  logic              unused_bits;

  logic [DIV_W-1:0]  div_q, div_d;
  logic              en_q, en_d;
  logic              irq_en_q, irq_en_d;
  logic              ovf_q, ovf_d;
  logic [BUS_W-1:0]  rd_data_q, rd_data_d;
  logic              irq_q, irq_d;

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  baud_q, baud_d;
  logic [DIV_W-1:0]  div_lat_q, div_lat_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              bit_done, can_start;

  assign wr_en   = bus_cs & bus_wr;
  assign rd_en   = bus_cs & bus_rd;
  assign reg_off = {bus_addr[3:2], 2'b00};
  assign push    = wr_en && (reg_off == OFF_TXDATA);
  assign clear   = wr_en && (reg_off == OFF_CTRL) && bus_wr_data[CTRL_CLEAR];
  assign ovf_set = push && fifo_full && !pop && !clear;

  assign unused_bits = ^{bus_addr[BUS_W-1:4], bus_addr[1:0], bus_wr_data[BUS_W-1:DIV_W]};

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wr_data (bus_wr_data[DATA_W-1:0]),
    .pop     (pop),
    .clear   (clear),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    status       = '0;
    status.full  = fifo_full;
    status.empty = fifo_empty;
    status.busy  = (state_q != TX_IDLE);
    status.ovf   = ovf_q;
    status.count = ST_CNT_W'(fifo_count);
  end

  // Read mux; TXDATA is write-only and reads back zero
  always_comb begin
    rd_mux = '0;
    case (reg_off)
      OFF_STATUS:  rd_mux = status;
      OFF_DIVISOR: rd_mux = BUS_W'(div_q);
      OFF_CTRL: begin
        rd_mux[CTRL_ENABLE] = en_q;
        rd_mux[CTRL_IRQ_EN] = irq_en_q;
      end
      default:     rd_mux = '0;
    endcase
  end

  // Register file next state; overflow set wins over a same-cycle clear
  always_comb begin
    div_d     = div_q;
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    ovf_d     = ovf_q;
    rd_data_d = rd_data_q;
    if (wr_en && (reg_off == OFF_DIVISOR)) div_d = bus_wr_data[DIV_W-1:0];
    if (wr_en && (reg_off == OFF_CTRL)) begin
      en_d     = bus_wr_data[CTRL_ENABLE];
      irq_en_d = bus_wr_data[CTRL_IRQ_EN];
    end
    if (wr_en && (reg_off == OFF_STATUS) && bus_wr_data[ST_OVF]) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
    if (rd_en) rd_data_d = rd_mux;
  end

  assign irq_d = irq_en_q & fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q     <= DIV_W'(DEFAULT_DIV);
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
    end
  end

  assign bit_done  = (baud_q == div_lat_q);
  assign can_start = en_q && !fifo_empty;

  // Transmit FSM; divisor is latched per frame so mid-frame writes wait for the next one
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    div_lat_d = div_lat_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    tx_d      = 1'b1;
    case (state_q)
      TX_IDLE: begin
        if (can_start) begin
          pop       = 1'b1;
          state_d   = TX_START;
          baud_d    = '0;
          div_lat_d = div_q;
          shift_d   = fifo_rd_data;
        end
      end
      TX_START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      TX_DATA: begin
        tx_d = shift_q[0];
        if (bit_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          if (bit_q == 3'd7) state_d = TX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      TX_STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          baud_d = '0;
          if (can_start) begin
            pop       = 1'b1;
            state_d   = TX_START;
            div_lat_d = div_q;
            shift_d   = fifo_rd_data;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= TX_IDLE;
      baud_q    <= '0;
      div_lat_q <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      div_lat_q <= div_lat_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign bus_rd_data = rd_data_q;
  assign tx          = tx_q;
  assign irq         = irq_q;

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter DEFAULT_DIV, default 433, DIVISOR reset value (bit period DIVISOR+1 clk cycles; 115200 baud at 50 MHz).
REQ-003 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port bus_cs, input, 1: peripheral selected this cycle.
REQ-006 SHALL have port bus_wr, input, 1: write strobe, qualified by bus_cs.
REQ-007 SHALL have port bus_rd, input, 1: read strobe, qualified by bus_cs.
REQ-008 SHALL have port bus_addr, input, 32: byte address; only bits [3:2] decoded.
REQ-009 SHALL have port bus_wr_data, input, 32: write data.
REQ-010 SHALL have port bus_rd_data, output, 32: registered read data.
REQ-011 SHALL have port tx, output, 1: serial line, idle high.
REQ-012 SHALL have port irq, output, 1: level interrupt, FIFO empty and IRQ_EN set.

Function
REQ-013 Register map SHALL be: 0x0 TXDATA (W: push [7:0]; R: 0), 0x4 STATUS (R), 0x8 DIVISOR (R/W [15:0]), 0xC CTRL (R/W).
REQ-014 STATUS SHALL be: [0] full, [1] empty, [2] busy (FSM not IDLE), [3] overflow (sticky, write 1 clears), [11:4] FIFO count; other bits 0.
REQ-015 CTRL SHALL be: [0] ENABLE, [1] IRQ_EN, [2] CLEAR (self-clearing, reads 0).
REQ-016 Reads SHALL be side-effect free; bus_rd_data SHALL update at the edge ending the read cycle and hold until the next read.
REQ-017 bus_wr and bus_rd together SHALL perform both; read returns pre-write value.
REQ-018 Push to full FIFO SHALL be dropped and set overflow, unless a pop occurs the same cycle, in which case push is accepted.
REQ-019 Transmit FSM SHALL have states IDLE, START, DATA, STOP; frame 8N1, LSB first.
REQ-020 IDLE->START SHALL occur when ENABLE=1 and FIFO non-empty; the byte is popped and DIVISOR latched on that edge.
REQ-021 Each of START, 8 DATA bits, STOP SHALL last latched DIVISOR+1 cycles; STOP->START directly if ENABLE and non-empty, else IDLE.
REQ-022 tx SHALL fall on the second rising edge after the edge capturing a TXDATA write into an empty FIFO with FSM IDLE and ENABLE=1.
REQ-023 DIVISOR writes mid-frame SHALL affect only the next frame; DIVISOR=0 SHALL give 1-cycle bits.
REQ-024 Clearing ENABLE mid-frame SHALL let the current frame complete; no further pops.
REQ-025 CLEAR SHALL empty FIFO in one cycle without aborting the current frame; CLEAR with simultaneous push discards the push.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL reach exactly FIFO_DEPTH when full.

Reset
REQ-027 reset_n low SHALL asynchronously force: FSM IDLE, tx=1, FIFO empty, overflow=0, CTRL=0, DIVISOR=DEFAULT_DIV, bus_rd_data=0, irq=0.
REQ-028 Reset mid-frame SHALL abort the frame; tx high immediately; no byte retained.
REQ-029 Deassertion SHALL be synchronised externally; block SHALL start IDLE on first clk edge after release.

Structure
REQ-030 Package uart_pkg SHALL hold register offsets, STATUS/CTRL bit indices, FSM state enum, DEFAULT_DIV.
REQ-031 FIFO SHALL be sub-module uart_tx_fifo (push, pop, clear, full, empty, count); FSM, divider, bit counter, register file in mmio_uart_tx.

Verification
REQ-032 Reset, read STATUS -> 0x0000_0002; DIVISOR -> 433; tx=1; irq=0.
REQ-033 DIVISOR=3, CTRL=1, write TXDATA 0xA5 -> tx low 2 edges later; bits 1,0,1,0,0,1,0,1 each 4 cycles; stop high 4 cycles; total 40 cycles; busy then 0.
REQ-034 ENABLE=0, push 9 bytes with FIFO_DEPTH=8 -> STATUS count 8, full=1, overflow=1; write STATUS 0x8 -> overflow 0, count 8.
REQ-035 DIVISOR=1, ENABLE=1, push 0x55 and 0x0F back-to-back -> frames contiguous, no idle between stop and second start; irq with IRQ_EN=1 asserts when second byte popped.
REQ-036 Mid-frame DIVISOR write 7 and CTRL CLEAR with 3 queued -> current frame keeps old timing, FIFO count 0, no further frames.
REQ-037 reset_n low during DATA bit 4 -> tx=1 same cycle; after release STATUS=0x0000_0002, no frame emitted.
